// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive sequencer:
//   - rx_state_t      : receive FSM state encoding
//   - CHK_OFFSET      : distance (in oversample edges) from the bit midpoint
//                       to the edge where the sampler's majority vote is valid
//   - PRESCALE_*      : the supported oversampling ratios
//   - is_legal_prescale / chk_edge : small helpers built on the above
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int         CHK_OFFSET  = 2;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic is_legal_prescale(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

    // Edge index at which the sampler output is settled: prescale/2 + CHK_OFFSET.
    function automatic logic [5:0] chk_edge(input logic [5:0] p);
        return (p >> 1) + 6'(CHK_OFFSET);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_counter
// Oversample edge counter plus bit counter for one UART frame.
// Ports:
//   clock, reset    : system clock, asynchronous active-low reset
//   i_prescale      : oversampling ratio (edge counter wraps at i_prescale-1)
//   i_clear         : hold both counters at 0 (receiver idle)
//   i_load          : start of frame: edge counter <- 1, bit counter <- 0
//   i_bit_inc       : advance the bit counter when the edge counter wraps
//   o_edge_count    : current oversample index inside the bit
//   o_bit_count     : number of completed bits counted since load
//   o_bit_end       : edge counter is at i_prescale-1 (last edge of the bit)
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] i_prescale,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_bit_inc,
    output logic [4:0] o_edge_count,
    output logic [3:0] o_bit_count,
    output logic       o_bit_end
);

    logic [4:0] r_edge;
    logic [3:0] r_bit;
    logic       w_bit_end;

    // Compared at 6 bits so prescale=32 (last edge 31) needs no special case.
    assign w_bit_end = ({1'b0, r_edge} == (i_prescale - 6'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_edge <= 5'd0;
            r_bit  <= 4'd0;
        end else if (i_load) begin
            // The edge where the falling start edge is seen counts as edge 0.
            r_edge <= 5'd1;
            r_bit  <= 4'd0;
        end else if (i_clear) begin
            r_edge <= 5'd0;
            r_bit  <= 4'd0;
        end else begin
            r_edge <= w_bit_end ? 5'd0 : r_edge + 5'd1;
            if (w_bit_end && i_bit_inc) begin
                r_bit <= r_bit + 4'd1;
            end
        end
    end

    assign o_edge_count = r_edge;
    assign o_bit_count  = r_bit;
    assign o_bit_end    = w_bit_end;

endmodule

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// Sequencing controller for the UART receive path. Walks each frame through
// START / DATA / PARITY / STOP using the oversample edge counter, fires a
// one-cycle enable to each checker at the settled sample edge, and turns the
// checkers' registered error flags into one data_valid or frame_error pulse.
// Ports:
//   clock, reset     : system clock, asynchronous active-low reset
//   rx_in            : serial line, idle high
//   prescale         : oversampling ratio (8/16/32), static while busy
//   parity_enable    : frame carries a parity bit (latched at start)
//   parity_error     : parity checker result, valid 1 cycle after par_chk_en
//   start_glitch     : start checker result, valid 1 cycle after strt_chk_en
//   stop_error       : stop checker result, valid 1 cycle after stp_chk_en
//   dat_samp_en      : sampler enable, high for the whole frame
//   edge_count       : oversample index inside the current bit
//   strt_chk_en, deser_en, par_chk_en, stp_chk_en : one-cycle strobes
//   data_valid       : one-cycle pulse, frame received without error
//   frame_error      : one-cycle pulse, frame ended with parity/stop error
//   busy             : receiver is inside a frame
//   dbg_state        : current FSM state
// Handshake: no back-pressure. Each strobe is a single-cycle enable; the
// addressed checker answers on its registered output one cycle later, and
// that answer is only consumed on the last edge of the same bit.
// ---------------------------------------------------------------------------
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       parity_enable,
    input  logic       parity_error,
    input  logic       start_glitch,
    input  logic       stop_error,
    output logic       dat_samp_en,
    output logic [4:0] edge_count,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy,
    output rx_state_t  dbg_state
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH - 1);

    rx_state_t  r_state;
    rx_state_t  w_state_next;
    logic [4:0] w_edge_count;
    logic [3:0] w_bit_count;
    logic       w_bit_end;
    logic       w_chk_hit;
    logic       w_start_det;
    logic       r_par_en;
    logic       r_par_flag;
    logic       r_data_valid;
    logic       r_frame_error;
    logic       w_strt;
    logic       w_deser;
    logic       w_par;
    logic       w_stp;

    // An illegal ratio would put the check edge past the bit end, so the
    // receiver simply stays idle until prescale is one of the legal values.
    assign w_start_det = (r_state == ST_IDLE) && !rx_in && is_legal_prescale(prescale);
    assign w_chk_hit   = ({1'b0, w_edge_count} == chk_edge(prescale));

    uart_rx_edge_bit_counter u_counter (
        .clock        (clock),
        .reset        (reset),
        .i_prescale   (prescale),
        .i_clear      (r_state == ST_IDLE),
        .i_load       (w_start_det),
        .i_bit_inc    (r_state == ST_DATA),
        .o_edge_count (w_edge_count),
        .o_bit_count  (w_bit_count),
        .o_bit_end    (w_bit_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and strobes. Strobes depend only on registered state and
    // counters; checker inputs are looked at only on the bit end of their
    // own state because the checkers hold stale results otherwise.
    always_comb begin
        w_state_next = r_state;
        w_strt       = 1'b0;
        w_deser      = 1'b0;
        w_par        = 1'b0;
        w_stp        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_det) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_strt = w_chk_hit;
                if (w_bit_end) begin
                    w_state_next = start_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                w_deser = w_chk_hit;
                if (w_bit_end && (w_bit_count == LAST_DATA_BIT)) begin
                    w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_par = w_chk_hit;
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_stp = w_chk_hit;
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame-scoped flags and the result pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par_en      <= 1'b0;
            r_par_flag    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_start_det) begin
                r_par_en   <= parity_enable;
                r_par_flag <= 1'b0;
            end
            if ((r_state == ST_PARITY) && w_bit_end) begin
                r_par_flag <= parity_error;
            end
            if ((r_state == ST_STOP) && w_bit_end) begin
                r_data_valid  <= !(r_par_flag || stop_error);
                r_frame_error <= r_par_flag || stop_error;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign dat_samp_en = (r_state != ST_IDLE);
    assign edge_count  = w_edge_count;
    assign strt_chk_en = w_strt;
    assign deser_en    = w_deser;
    assign par_chk_en  = w_par;
    assign stp_chk_en  = w_stp;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       parity_enable = 1'b0;
    logic       parity_error = 1'b0;
    logic       start_glitch = 1'b0;
    logic       stop_error = 1'b0;
    logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_error, busy;
    logic [4:0] edge_count;
    rx_state_t  dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_in         (rx_in),
        .prescale      (prescale),
        .parity_enable (parity_enable),
        .parity_error  (parity_error),
        .start_glitch  (start_glitch),
        .stop_error    (stop_error),
        .dat_samp_en   (dat_samp_en),
        .edge_count    (edge_count),
        .strt_chk_en   (strt_chk_en),
        .deser_en      (deser_en),
        .par_chk_en    (par_chk_en),
        .stp_chk_en    (stp_chk_en),
        .data_valid    (data_valid),
        .frame_error   (frame_error),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int last_pulse = -1;
    int prev_pulse = -1;
    logic [33:0] exp_q[$];   // {cycle[31:0], data_valid, frame_error}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (data_valid && frame_error) begin
                checks++;
                errors++;
                $display("FAIL both_pulses cycle %0d: data_valid and frame_error both 1, expected at most one", cyc);
            end
            if (data_valid || frame_error) begin
                logic [33:0] e;
                prev_pulse = last_pulse;
                last_pulse = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cycle %0d: got dv=%0b fe=%0b expected no pulse",
                             cyc, data_valid, frame_error);
                end else begin
                    e = exp_q.pop_front();
                    if ({32'(cyc), data_valid, frame_error} !== e) begin
                        errors++;
                        $display("FAIL pulse cycle %0d: got dv=%0b fe=%0b expected cycle %0d dv=%0b fe=%0b",
                                 cyc, data_valid, frame_error, e[33:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    // ---------------- reference model of per-cycle outputs ----------------
    // Returns {busy, dat_samp_en, edge_count, strt, deser, par, stp} at frame
    // offset o (o=0 is the cycle in which rx_in first goes low).
    function automatic logic [10:0] exp_vec(input int o, input int p, input bit par_en, input bit glitch);
        int total, b, e, chk;
        logic s, d, pp, st;
        total = glitch ? p : (2 + DW + (par_en ? 1 : 0)) * p;
        if (o == 0 || o >= total) return 11'd0;
        b   = o / p;
        e   = o % p;
        chk = p / 2 + 2;
        s   = (b == 0) && (e == chk);
        d   = (b >= 1) && (b <= DW) && (e == chk);
        pp  = par_en && (b == DW + 1) && (e == chk);
        st  = (b == total / p - 1) && (b != 0) && (e == chk);
        return {1'b1, 1'b1, 5'(e), s, d, pp, st};
    endfunction

    // ---------------- driver ----------------
    task automatic run_frame(input int p, input bit par_en, input logic [7:0] data, input bit glitch,
                             input bit par_err, input bit stp_err, input bit exp_dv, input bit exp_fe,
                             input bit b2b);
        int total, last, k, b, n_deser, n_par;
        logic ap_g, ap_p, ap_s, v_g, v_p, v_s;
        total   = glitch ? p : (2 + DW + (par_en ? 1 : 0)) * p;
        last    = b2b ? total - 1 : total + 1;
        k       = 0;
        n_deser = 0;
        n_par   = 0;
        {ap_g, ap_p, ap_s, v_g, v_p, v_s} = '0;
        for (int o = 0; o <= last; o++) begin
            @(negedge clock);
            if (o == 0) begin
                k = cyc;
                prescale      = 6'(p);
                parity_enable = par_en;
                // stale checker outputs from "earlier" use; must be ignored
                parity_error  = 1'($urandom_range(0, 1));
                stop_error    = 1'($urandom_range(0, 1));
                start_glitch  = 1'($urandom_range(0, 1));
                if (!glitch) exp_q.push_back({32'(k + total), exp_dv, exp_fe});
            end
            // registered checker model: answer appears one cycle after strobe
            if (ap_g) start_glitch = v_g;
            if (ap_p) parity_error = v_p;
            if (ap_s) stop_error   = v_s;
            {ap_g, ap_p, ap_s} = '0;
            b = o / p;
            if (o == 0)                          rx_in = 1'b0;
            else if (glitch || o >= total)       rx_in = 1'b1;
            else if (b == 0)                     rx_in = 1'b0;
            else if (b <= DW)                    rx_in = data[b-1];
            else if (par_en && b == DW + 1)      rx_in = ^data;
            else                                 rx_in = 1'b1;
            chk("frame_outputs", 32'({busy, dat_samp_en, edge_count, strt_chk_en, deser_en, par_chk_en, stp_chk_en}),
                32'(exp_vec(o, p, par_en, glitch)));
            if (deser_en) n_deser++;
            if (par_chk_en) n_par++;
            if (strt_chk_en) begin ap_g = 1'b1; v_g = glitch;  end
            if (par_chk_en)  begin ap_p = 1'b1; v_p = par_err; end
            if (stp_chk_en)  begin ap_s = 1'b1; v_s = stp_err; end
        end
        chk("deser_count", 32'(n_deser), glitch ? 32'd0 : 32'(DW));
        chk("par_strobe_count", 32'(n_par), (glitch || !par_en) ? 32'd0 : 32'd1);
        if (!b2b) chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        int         p;
        bit         par_en;
        logic [7:0] data;
        bit         par_err;
        bit         stp_err;
        bit         exp_dv;
        bit         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8,  1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, 1'b0};

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({busy, dat_samp_en, edge_count, strt_chk_en, deser_en, par_chk_en,
                                  stp_chk_en, data_valid, frame_error}), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;

        // first frame's start edge lands in cycle 10
        while (cyc != 9) @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].p, vecs[i].par_en, vecs[i].data, 1'b0, vecs[i].par_err, vecs[i].stp_err,
                      vecs[i].exp_dv, vecs[i].exp_fe, 1'b0);
            if (i == 0) chk("first_pulse_cycle", 32'(last_pulse), 32'd98);
        end

        // start glitch: back to idle after one bit, no pulse
        run_frame(8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back frames
        run_frame(8, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(8, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(last_pulse - prev_pulse), 32'd88);

        // reset in the middle of data bit 4
        @(negedge clock);
        prescale = 6'd8;
        parity_enable = 1'b1;
        rx_in = 1'b0;
        @(negedge clock);
        rx_in = 1'b1;
        for (int o = 2; o <= 43; o++) @(negedge clock);
        chk("pre_reset_state", 32'(dbg_state), 32'(ST_DATA));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({busy, dat_samp_en, edge_count, strt_chk_en, deser_en, par_chk_en,
                                        stp_chk_en, data_valid, frame_error}), 32'd0);
        chk("async_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        run_frame(8, 1'b0, 8'h5E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clock);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
